pong_sound: RTL and testbench



---
 rtl/pong_sound.sv | 108 ++++++++++
 tb/tb_pong_sound.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pong_sound.sv
// Square-wave tone generator fed by the hit/wall/score sound timers.
// Picks the highest-priority active source and emits its tone on the falling clock edge.
module pong_sound #(
  parameter int unsigned        CLK_FREQ  = 0,
  parameter int unsigned        HIT_HZ    = 491,
  parameter int unsigned        WALL_HZ   = 246,
  parameter int unsigned        SCORE_HZ  = 123,
  parameter logic signed [15:0] AMPLITUDE = 16'sd8192
) (
  input  logic               _clk,
  input  logic               reset,
  input  logic               hit_en,
  input  logic               wall_en,
  input  logic               score_en,
  input  logic               mute,
  output logic               sound,
  output logic signed [15:0] audio,
  output logic [1:0]         active
);

  typedef enum logic [1:0] {SelNone, SelWall, SelHit, SelScore} sel_e;

  function automatic logic [31:0] half_of(int unsigned hz);
    int unsigned q;
    if (hz == 0) return 32'd1;
    q = CLK_FREQ / (2 * hz);
    return (q == 0) ? 32'd1 : q;
  endfunction

  localparam logic [31:0] HalfHit   = half_of(HIT_HZ);
  localparam logic [31:0] HalfWall  = half_of(WALL_HZ);
  localparam logic [31:0] HalfScore = half_of(SCORE_HZ);

  logic [2:0]         en_q;  // {score, hit, wall}
  logic               mute_q;
  sel_e               sel, sel_q;
  logic [31:0]        half_sel;
  logic [31:0]        cnt_q, cnt_d;
  logic               tone_q, tone_d;
  logic               sound_d;
  logic signed [15:0] audio_d;

  // A source whose frequency is 0 can never win arbitration.
  always_comb begin
    sel = SelNone;
    if (en_q[2] && SCORE_HZ != 0)    sel = SelScore;
    else if (en_q[1] && HIT_HZ != 0)  sel = SelHit;
    else if (en_q[0] && WALL_HZ != 0) sel = SelWall;
  end

  always_comb begin
    half_sel = 32'd1;
    unique case (sel)
      SelWall:  half_sel = HalfWall;
      SelHit:   half_sel = HalfHit;
      SelScore: half_sel = HalfScore;
      default:  half_sel = 32'd1;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (sel != sel_q) begin
      // Source change: every new tone starts with a full high half-period.
      cnt_d  = (sel == SelNone) ? 32'd0 : half_sel - 32'd1;
      tone_d = (sel != SelNone);
    end else if (sel != SelNone) begin
      if (cnt_q == 32'd0) begin
        tone_d = ~tone_q;
        cnt_d  = half_sel - 32'd1;
      end else begin
        cnt_d  = cnt_q - 32'd1;
      end
    end else begin
      cnt_d  = 32'd0;
      tone_d = 1'b0;
    end

    sound_d = tone_d & ~mute_q;
    audio_d = 16'sd0;
    if (sound_d)                          audio_d = AMPLITUDE;
    else if (sel != SelNone && !mute_q)   audio_d = -AMPLITUDE;
  end

  always_ff @(negedge _clk) begin
    if (reset) begin
      en_q   <= 3'b000;
      mute_q <= 1'b0;
      sel_q  <= SelNone;
      cnt_q  <= 32'd0;
      tone_q <= 1'b0;
      sound  <= 1'b0;
      audio  <= 16'sd0;
    end else begin
      en_q   <= {score_en, hit_en, wall_en};
      mute_q <= mute;
      sel_q  <= sel;
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
      sound  <= sound_d;
      audio  <= audio_d;
    end
  end

  assign active = sel_q;

endmodule

// File: tb/tb_pong_sound.sv
// Bench for pong_sound: a phase-from-start-time model checked on every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pong_sound;

  logic               clk, reset, hit_en, wall_en, score_en, mute;
  logic               sound;
  logic signed [15:0] audio;
  logic [1:0]         active;

  int tests = 0;
  int fails = 0;

  pong_sound #(
    .CLK_FREQ (4000),
    .HIT_HZ   (500),
    .WALL_HZ  (250),
    .SCORE_HZ (125)
  ) dut (
    ._clk     (clk),
    .reset    (reset),
    .hit_en   (hit_en),
    .wall_en  (wall_en),
    .score_en (score_en),
    .mute     (mute),
    .sound    (sound),
    .audio    (audio),
    .active   (active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a tone is high during even-numbered half-periods counted from the
  // edge at which its source became selected.
  function automatic int half_of(input int s);
    case (s)
      1:       return 8;
      2:       return 4;
      3:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int prio(input logic [2:0] en);
    if (en[2]) return 3;
    if (en[1]) return 2;
    if (en[0]) return 1;
    return 0;
  endfunction

  logic [2:0]         m_en;
  logic               m_mute;
  logic               m_valid = 1'b0;
  int                 m_sel, m_start, m_s, edge_n = 0;
  logic               e_sound;
  logic signed [15:0] e_audio;
  logic [1:0]         e_active;

  always @(negedge clk) begin
    if (reset) begin
      m_en = 3'b000; m_mute = 1'b0; m_sel = 0; m_start = 0;
      e_sound = 1'b0; e_audio = 16'sd0; e_active = 2'd0;
    end else begin
      m_s = prio(m_en);
      if (m_s != m_sel) begin
        m_sel   = m_s;
        m_start = edge_n;
      end
      e_sound  = (m_s != 0) && (((edge_n - m_start) / half_of(m_s)) % 2 == 0) && !m_mute;
      e_audio  = e_sound ? 16'sd8192 : ((m_s != 0 && !m_mute) ? -16'sd8192 : 16'sd0);
      e_active = 2'(m_s);
      m_en     = {score_en, hit_en, wall_en};
      m_mute   = mute;
    end
    edge_n++;
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    if (m_valid) begin
      chk("model_sound", int'(sound), int'(e_sound));
      chk("model_audio", int'(audio), int'(e_audio));
      chk("model_active", int'(active), int'(e_active));
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk_out(input string name, input int s, input int a, input int act);
    chk({name, "_sound"}, int'(sound), s);
    chk({name, "_audio"}, int'(audio), a);
    chk({name, "_active"}, int'(active), act);
  endtask

  initial begin
    reset = 1'b1; hit_en = 1'b0; wall_en = 1'b0; score_en = 1'b0; mute = 1'b0;
    ticks(1);

    // Reset held with all inputs high
    hit_en = 1'b1; wall_en = 1'b1; score_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      chk_out("reset_hold", 0, 0, 0);
    end
    reset = 1'b0;
    ticks(1); chk("reset_rel1_active", int'(active), 0);
    ticks(1); chk("reset_rel2_active", int'(active), 3);
    hit_en = 1'b0; wall_en = 1'b0; score_en = 1'b0;
    ticks(5);

    // Hit alone: 4 high / 4 low
    hit_en = 1'b1;
    ticks(1); chk("hit_lat1_active", int'(active), 0);
    ticks(1); chk_out("hit_start", 1, 8192, 2);
    ticks(3); chk_out("hit_high_end", 1, 8192, 2);
    ticks(1); chk_out("hit_low", 0, -8192, 2);
    ticks(4); chk_out("hit_high2", 1, 8192, 2);
    ticks(30);
    hit_en = 1'b0;
    ticks(2); chk_out("hit_off", 0, 0, 0);
    ticks(3);

    // Priority: wall, then score preempts, then back to wall
    wall_en = 1'b1;
    ticks(2); chk_out("wall_start", 1, 8192, 1);
    ticks(8);
    score_en = 1'b1;
    ticks(2); chk_out("score_start", 1, 8192, 3);
    ticks(15); chk_out("score_high_end", 1, 8192, 3);
    ticks(1); chk_out("score_low", 0, -8192, 3);
    ticks(5);
    score_en = 1'b0;
    ticks(2); chk_out("wall_resume", 1, 8192, 1);
    ticks(7); chk_out("wall_high_end", 1, 8192, 1);
    ticks(1); chk_out("wall_low", 0, -8192, 1);
    wall_en = 1'b0;
    ticks(4);

    // Simultaneous hit and wall
    hit_en = 1'b1; wall_en = 1'b1;
    ticks(2); chk_out("simul_start", 1, 8192, 2);
    ticks(4); chk_out("simul_low", 0, -8192, 2);
    ticks(10);
    hit_en = 1'b0; wall_en = 1'b0;
    ticks(4);

    // Mute during hit tone, released mid-half-period
    hit_en = 1'b1;
    ticks(2); chk_out("mute_pre", 1, 8192, 2);
    ticks(1);
    mute = 1'b1;
    ticks(1); chk_out("mute_capture", 1, 8192, 2);
    ticks(1); chk_out("mute_on", 0, 0, 2);
    ticks(2);
    mute = 1'b0;
    ticks(2); chk_out("unmute_low", 0, -8192, 2);
    ticks(1); chk_out("unmute_high", 1, 8192, 2);

    // One-cycle dropout restarts the phase
    hit_en = 1'b0;
    ticks(1);
    hit_en = 1'b1;
    ticks(1); chk_out("drop_none", 0, 0, 0);
    ticks(1); chk_out("drop_restart", 1, 8192, 2);
    ticks(3); chk_out("drop_high_end", 1, 8192, 2);
    ticks(1); chk_out("drop_low", 0, -8192, 2);
    ticks(4); chk_out("pre_reset_high", 1, 8192, 2);

    // Reset mid-high
    reset = 1'b1;
    ticks(1); chk_out("mid_reset", 0, 0, 0);
    reset = 1'b0; hit_en = 1'b0;
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
